// File: rtl/sram_uart_tx_interface_pkg.sv
// Shared types and defaults for the SRAM-to-UART dump path.
package milestone_pkg;
  localparam int UART_CLK_PER_BIT = 434;
  localparam int SRAM_RD_LAT      = 2;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_FETCH,
    S_TX_WAIT,
    S_TX_HI,
    S_TX_LO,
    S_TX_FLUSH,
    S_TX_DONE
  } tx_state_type;
endpackage

// File: rtl/sram_uart_tx_interface_uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake; a new byte may be accepted
// in the last cycle of the stop bit so frames run back-to-back.
module uart_tx_byte #(
  parameter int CLK_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);
  localparam int BW = $clog2(CLK_PER_BIT);

  logic          active;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          accept;

  assign bit_end    = baud_cnt == BW'(CLK_PER_BIT - 1);
  assign byte_ready = !active || (bit_cnt == 4'd9 && bit_end);
  assign accept     = byte_valid && byte_ready;

  // bit_cnt 0 is the start bit, 1..8 data LSB first, 9 the stop bit
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      active   <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (accept) begin
      active   <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shreg    <= byte_data;
      tx       <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) begin
            tx <= 1'b1;
          end else begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end
endmodule

// File: rtl/sram_uart_tx_interface.sv
// Streams a block of 16-bit SRAM words out of the UART, high byte first.
// Optional SRAM_TX_CHECKSUM_EN appends a two's-complement checksum byte.
module sram_uart_tx_interface
  import milestone_pkg::*;
#(
  parameter int CLK_PER_BIT       = UART_CLK_PER_BIT,
  parameter int SRAM_READ_LATENCY = SRAM_RD_LAT
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  input  logic [17:0] base_address,
  input  logic [17:0] word_count,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        busy,
  output logic        done
);
  localparam int WW = $clog2(SRAM_READ_LATENCY + 1);

  tx_state_type  state, state_next;
  logic [17:0]   addr;
  logic [17:0]   remaining;
  logic [15:0]   word_buf;
  logic [WW-1:0] wait_cnt;
  logic          wait_last;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;

`ifdef SRAM_TX_CHECKSUM_EN
  logic [7:0] ck_sum;
  logic       ck_pending;
`endif

  assign wait_last    = wait_cnt == WW'(SRAM_READ_LATENCY - 1);
  assign SRAM_address = addr;
  assign SRAM_we_n    = 1'b1;
  assign busy         = state != S_TX_IDLE;
  assign done         = state == S_TX_DONE;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) state <= S_TX_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_valid = 1'b0;
    byte_data  = word_buf[15:8];
    case (state)
      S_TX_IDLE:  if (start) state_next = (word_count == 18'd0) ? S_TX_DONE : S_TX_FETCH;
      S_TX_FETCH: state_next = S_TX_WAIT;
      S_TX_WAIT:  if (wait_last) state_next = S_TX_HI;
      S_TX_HI: begin
        byte_valid = 1'b1;
        if (byte_ready) state_next = S_TX_LO;
      end
      S_TX_LO: begin
        byte_valid = 1'b1;
        byte_data  = word_buf[7:0];
        // next word is fetched while the low byte is still on the line
        if (byte_ready) state_next = (remaining == 18'd1) ? S_TX_FLUSH : S_TX_FETCH;
      end
      S_TX_FLUSH: begin
`ifdef SRAM_TX_CHECKSUM_EN
        byte_valid = ck_pending;
        byte_data  = 8'(~ck_sum + 8'd1);
        if (byte_ready && !ck_pending) state_next = S_TX_DONE;
`else
        if (byte_ready) state_next = S_TX_DONE;
`endif
      end
      S_TX_DONE:  state_next = S_TX_IDLE;
      default:    state_next = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      addr      <= '0;
      remaining <= '0;
      word_buf  <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_TX_IDLE: if (start) begin
          addr      <= base_address;
          remaining <= word_count;
        end
        S_TX_FETCH: wait_cnt <= '0;
        S_TX_WAIT: begin
          if (wait_last) word_buf <= SRAM_read_data;
          else           wait_cnt <= wait_cnt + WW'(1);
        end
        S_TX_LO: if (byte_ready) begin
          remaining <= remaining - 18'd1;
          addr      <= addr + 18'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_TX_CHECKSUM_EN
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      ck_sum     <= '0;
      ck_pending <= 1'b0;
    end else begin
      if (state == S_TX_IDLE && start) ck_sum <= '0;
      if ((state == S_TX_HI || state == S_TX_LO) && byte_ready)
        ck_sum <= ck_sum + byte_data;
      if (state == S_TX_LO && byte_ready && remaining == 18'd1) ck_pending <= 1'b1;
      if (state == S_TX_FLUSH && byte_ready && ck_pending)      ck_pending <= 1'b0;
    end
  end
`endif

  uart_tx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
    .clock      (CLOCK_50_I),
    .resetn     (resetn),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .tx         (UART_TX_O)
  );
endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Bench: behavioural SRAM plus a UART line decoder; expected byte streams are
// built from memory contents and compared with what appears on the line.
module tb_sram_uart_tx_interface;
  localparam int CPB = 4;
  localparam int LAT = 2;
  localparam int FRAME = 10 * CPB;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [17:0] base_address;
  logic [17:0] word_count;
  logic [15:0] sram_rd;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        uart_tx;
  logic        busy;
  logic        done;

  sram_uart_tx_interface #(.CLK_PER_BIT(CPB), .SRAM_READ_LATENCY(LAT)) dut (
    .CLOCK_50_I     (clk),
    .resetn         (resetn),
    .start          (start),
    .base_address   (base_address),
    .word_count     (word_count),
    .SRAM_read_data (sram_rd),
    .SRAM_address   (sram_addr),
    .SRAM_we_n      (sram_we_n),
    .UART_TX_O      (uart_tx),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM: data valid LAT cycles after the address changes
  logic [15:0] mem [0:262143];
  logic [15:0] p1;
  always @(posedge clk) begin
    p1      <= mem[sram_addr];
    sram_rd <= p1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // line decoder: samples each bit at its middle
  logic [7:0] rx_q[$];
  int         fall_q[$];
  int         done_q[$];
  int         stop_err = 0;
  int         mon_f;
  logic [7:0] mon_b;

  initial begin
    forever begin
      @(negedge clk);
      if (resetn && !uart_tx) begin
        mon_f = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (!uart_tx) stop_err++;
        rx_q.push_back(mon_b);
        fall_q.push_back(mon_f);
      end
    end
  end

  always @(negedge clk) if (done) done_q.push_back(cyc);

  task automatic run_xfer(input logic [17:0] b, input int n, input bit inject, input string tag);
    logic [7:0]  exp_q[$];
    logic [15:0] w;
    int          s;
    int          sum;
    int          nsp;
    bit          to;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      w = mem[(int'(b) + i) & 32'h3FFFF];
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      sum += int'(w[15:8]) + int'(w[7:0]);
    end
`ifdef SRAM_TX_CHECKSUM_EN
    if (n > 0) exp_q.push_back(8'((256 - (sum % 256)) % 256));
`endif
    rx_q.delete(); fall_q.delete(); done_q.delete(); stop_err = 0;
    @(negedge clk);
    base_address = b; word_count = 18'(n); start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_after_start"}, busy, 1);
    if (inject) begin
      repeat (20) @(negedge clk);
      base_address = b + 18'd5; word_count = 18'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    to = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if (!busy) begin to = 1'b0; break; end
      @(negedge clk);
    end
    chk({tag, ".timeout"}, to, 0);
    repeat (3) @(negedge clk);
    chk({tag, ".nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s.byte%0d", tag, i), rx_q[i], exp_q[i]);
    chk({tag, ".stop_bits"}, stop_err, 0);
    nsp = 0;
    for (int i = 1; i < fall_q.size(); i++) if (fall_q[i] - fall_q[i-1] != FRAME) nsp++;
    chk({tag, ".spacing"}, nsp, 0);
    chk({tag, ".ndone"}, done_q.size(), 1);
    if (done_q.size() > 0) begin
      if (n == 0) chk({tag, ".done_fast"}, (done_q[0] - s) <= 3, 1);
      else if (fall_q.size() > 0)
        chk({tag, ".done_delay"}, done_q[0] - fall_q[fall_q.size()-1], FRAME);
    end
    chk({tag, ".busy_end"}, busy, 0);
  endtask

  bit to2;

  initial begin
    resetn = 1'b0; start = 1'b0; base_address = '0; word_count = '0;
    repeat (3) @(negedge clk);
    chk("rst.tx", uart_tx, 1);
    chk("rst.addr", sram_addr, 0);
    chk("rst.we_n", sram_we_n, 1);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    mem[18'h00010] = 16'hA55A;
    run_xfer(18'h00010, 1, 1'b0, "s1");
    if (fall_q.size() > 0 && done_q.size() > 0)
      chk("s1.done_from_first_start", done_q[0] - fall_q[0], 2 * FRAME);

    mem[18'h00100] = 16'h0102; mem[18'h00101] = 16'h0304; mem[18'h00102] = 16'h0506;
    run_xfer(18'h00100, 3, 1'b0, "s2");

    run_xfer(18'h02000, 0, 1'b0, "s3");

    mem[18'h3FFFF] = 16'h1234; mem[18'h00000] = 16'hABCD;
    run_xfer(18'h3FFFF, 2, 1'b0, "s4");

    mem[18'h00200] = 16'hC3E1; mem[18'h00201] = 16'h7F80;
    for (int i = 5; i < 12; i++) mem[18'h00200 + 18'(i)] = 16'hEEEE;
    run_xfer(18'h00200, 2, 1'b1, "s5");

    for (int r = 0; r < 4; r++) begin
      logic [17:0] rb;
      int          rn;
      rb = 18'($urandom);
      rn = int'($urandom_range(1, 3));
      for (int i = 0; i < rn; i++) mem[18'(int'(rb) + i)] = 16'($urandom);
      run_xfer(rb, rn, 1'b0, $sformatf("rnd%0d", r));
    end

`ifdef SRAM_TX_CHECKSUM_EN
    mem[18'h00300] = 16'h0102; mem[18'h00301] = 16'h0304;
    run_xfer(18'h00300, 2, 1'b0, "s6");
    if (rx_q.size() == 5) chk("s6.checksum", rx_q[4], 8'hF6);
    else chk("s6.checksum_count", rx_q.size(), 5);
`endif

    // reset during data bit 3 (frame bit 4), which is 0 in this word
    mem[18'h00400] = 16'h0000; mem[18'h00401] = 16'h0000;
    @(negedge clk);
    base_address = 18'h00400; word_count = 18'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to2 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (!uart_tx) begin to2 = 1'b0; break; end
      @(negedge clk);
    end
    chk("s5r.fall_timeout", to2, 0);
    repeat (4 * CPB + 1) @(negedge clk);
    chk("s5r.tx_low_before_reset", uart_tx, 0);
    #1 resetn = 1'b0;
    #1;
    chk("s5r.tx_after_reset", uart_tx, 1);
    chk("s5r.busy_after_reset", busy, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    chk("s5r.tx_idle", uart_tx, 1);
    chk("s5r.busy_idle", busy, 0);
    chk("s5r.addr", sram_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
